pcpi_issuer: RTL and testbench

- CPU-side initiator for the PCPI co-processor bus; it drives a PCPI responder such as the M-extension unit.
- Accepts one instruction and its two operands from the core over a valid/ready request port.
- Presents them on PCPI and holds them stable until the responder signals ready, or until a no-busy timeout expires.
- Returns the write-back result, or an illegal-instruction trap, over a valid/ready response port.

---
 rtl/pcpi_issuer.sv | 112 +++++++++++
 tb/tb_pcpi_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_issuer.sv
// CPU-side PCPI initiator: issues one instruction to a co-processor, waits for its result or a
// no-responder timeout, and returns the write-back (or an illegal-instruction trap) to the core.
module pcpi_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,

  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_busy,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_wr,
  output logic [4:0]  resp_rd_addr,
  output logic [31:0] resp_data,
  output logic        resp_trap
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  // Set once the responder has claimed the instruction; busy time is then unbounded.
  logic       cnt_dis_q;

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      cnt_dis_q    <= 1'b0;
      pcpi_valid   <= 1'b0;
      pcpi_insn    <= 32'd0;
      pcpi_rs1     <= 32'd0;
      pcpi_rs2     <= 32'd0;
      resp_valid   <= 1'b0;
      resp_wr      <= 1'b0;
      resp_rd_addr <= 5'd0;
      resp_data    <= 32'd0;
      resp_trap    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            pcpi_insn  <= req_insn;
            pcpi_rs1   <= req_rs1;
            pcpi_rs2   <= req_rs2;
            pcpi_valid <= 1'b1;
            cnt_q      <= 8'd0;
            cnt_dis_q  <= 1'b0;
            state_q    <= StIssue;
          end
        end

        StIssue: begin
          // Ready wins over busy and over a timeout expiring in the same cycle.
          if (pcpi_ready) begin
            resp_wr      <= pcpi_wr;
            resp_data    <= pcpi_wr ? pcpi_rd : 32'd0;
            resp_rd_addr <= pcpi_insn[11:7];
            resp_trap    <= 1'b0;
            pcpi_valid   <= 1'b0;
            resp_valid   <= 1'b1;
            state_q      <= StResp;
          end else if (pcpi_busy) begin
            cnt_q     <= 8'd0;
            cnt_dis_q <= 1'b1;
          end else if (!cnt_dis_q) begin
            if (cnt_q == CntLast) begin
              resp_wr      <= 1'b0;
              resp_data    <= 32'd0;
              resp_rd_addr <= pcpi_insn[11:7];
              resp_trap    <= 1'b1;
              pcpi_valid   <= 1'b0;
              resp_valid   <= 1'b1;
              state_q      <= StResp;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end

        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_trap  <= 1'b0;
            state_q    <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_issuer.sv
// Directed bench for pcpi_issuer: a scripted PCPI responder per scenario with hand-computed
// expected responses, timing and trap behaviour.
module tb_pcpi_issuer;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_wr;
  logic [4:0]  resp_rd_addr;
  logic [31:0] resp_data;
  logic        resp_trap;

  int n_checks = 0;
  int n_fail   = 0;

  pcpi_issuer #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_insn     (req_insn),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_ready   (pcpi_ready),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_busy    (pcpi_busy),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_wr      (resp_wr),
    .resp_rd_addr (resp_rd_addr),
    .resp_data    (resp_data),
    .resp_trap    (resp_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one request for a single cycle; returns at the negedge of the first ISSUE cycle.
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    @(negedge clk);
    req_valid = 1'b0;
    req_insn  = 32'd0;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
  endtask

  // Scripted responder: pre_n quiet cycles, busy_n busy cycles, post_n quiet cycles, then one
  // ready cycle. Reports how many of those cycles had pcpi_valid high and whether operands held.
  task automatic respond(input int pre_n, input int busy_n, input int post_n, input logic wr,
                         input logic [31:0] rd, output int vcyc, output bit stable);
    logic [31:0] i0, a0, b0;
    int          total;
    i0 = pcpi_insn;
    a0 = pcpi_rs1;
    b0 = pcpi_rs2;
    vcyc = 0;
    stable = 1'b1;
    total = pre_n + busy_n + post_n + 1;
    for (int c = 0; c < total; c++) begin
      pcpi_busy  = (c >= pre_n) && (c < pre_n + busy_n);
      pcpi_ready = (c == total - 1);
      pcpi_wr    = pcpi_ready ? wr : 1'b0;
      pcpi_rd    = pcpi_ready ? rd : 32'd0;
      if (pcpi_valid === 1'b1) vcyc++;
      if (pcpi_insn !== i0 || pcpi_rs1 !== a0 || pcpi_rs2 !== b0) stable = 1'b0;
      @(negedge clk);
    end
    pcpi_busy  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'd0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 1'b0; req_insn = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0; pcpi_busy = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pcpi_valid, resp_valid, resp_wr, resp_trap} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {pcpi_valid, resp_valid, resp_wr, resp_trap});
    end
    n_checks++;
    if ({pcpi_insn, pcpi_rs1, pcpi_rs2, resp_data, resp_rd_addr} !== 133'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {pcpi_insn, pcpi_rs1, pcpi_rs2, resp_data, resp_rd_addr});
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int vcyc; bit stable;
    issue(32'h022081B3, 32'd7, 32'd6);
    n_checks++;
    if (pcpi_insn !== 32'h022081B3 || pcpi_rs1 !== 32'd7 || pcpi_rs2 !== 32'd6) begin
      n_fail++;
      $display("FAIL mul_issue: got %h/%h/%h required 022081b3/7/6", pcpi_insn, pcpi_rs1, pcpi_rs2);
    end
    respond(1, 3, 0, 1'b1, 32'h2A, vcyc, stable);
    n_checks++;
    if (vcyc != 5) begin n_fail++; $display("FAIL mul_valid_cycles: got %0d required 5", vcyc); end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL mul_operand_stable: got 0 required 1"); end
    n_checks++;
    if (pcpi_valid !== 1'b0 || resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL mul_valid_flip: got pv=%b rv=%b required 0/1", pcpi_valid, resp_valid);
    end
    n_checks++;
    if ({resp_wr, resp_rd_addr, resp_data, resp_trap} !== {1'b1, 5'd3, 32'h2A, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_resp: got wr=%b rd=%0d data=%h trap=%b required 1/3/0000002a/0",
               resp_wr, resp_rd_addr, resp_data, resp_trap);
    end
    handshake();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_done: got rv=%b rr=%b required 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_div_long_busy();
    int vcyc; bit stable;
    issue(32'h0220C2B3, 32'hFFFFFFEC, 32'd3);
    respond(1, 35, 0, 1'b1, 32'hFFFFFFFA, vcyc, stable);
    n_checks++;
    if (vcyc != 37 || !stable) begin
      n_fail++; $display("FAIL div_valid_cycles: got %0d stable=%b required 37/1", vcyc, stable);
    end
    n_checks++;
    if ({resp_valid, resp_wr, resp_rd_addr, resp_data, resp_trap} !==
        {1'b1, 1'b1, 5'd5, 32'hFFFFFFFA, 1'b0}) begin
      n_fail++;
      $display("FAIL div_resp: got v=%b wr=%b rd=%0d data=%h trap=%b required 1/1/5/fffffffa/0",
               resp_valid, resp_wr, resp_rd_addr, resp_data, resp_trap);
    end
    handshake();
  endtask

  task automatic test_busy_sticky();
    int vcyc; bit stable;
    // Quiet cycles after busy must not restart the timeout.
    issue(32'h022081B3, 32'd1, 32'd2);
    respond(1, 2, 20, 1'b1, 32'h77, vcyc, stable);
    n_checks++;
    if (vcyc != 24) begin n_fail++; $display("FAIL sticky_valid_cycles: got %0d required 24", vcyc); end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_trap !== 1'b0 || resp_data !== 32'h77) begin
      n_fail++;
      $display("FAIL sticky_resp: got v=%b trap=%b data=%h required 1/0/00000077",
               resp_valid, resp_trap, resp_data);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int first;
    issue(32'h0000000B, 32'd5, 32'd9);
    first = -1;
    for (int n = 0; n < 40 && first < 0; n++) begin
      if (resp_valid === 1'b1) first = n;
      else @(negedge clk);
    end
    n_checks++;
    if (first != 16) begin n_fail++; $display("FAIL timeout_latency: got %0d required 16", first); end
    n_checks++;
    if ({pcpi_valid, resp_trap, resp_wr, resp_data} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL timeout_resp: got pv=%b trap=%b wr=%b data=%h required 0/1/0/0",
               pcpi_valid, resp_trap, resp_wr, resp_data);
    end
    handshake();
    n_checks++;
    if (resp_trap !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got trap=%b rv=%b required 0/0", resp_trap, resp_valid);
    end
  endtask

  task automatic test_backpressure();
    int vcyc; bit stable; int bad;
    issue(32'h022081B3, 32'd9, 32'd5);
    respond(1, 3, 0, 1'b1, 32'd45, vcyc, stable);
    // A competing request during backpressure must not be taken.
    req_valid = 1'b1; req_insn = 32'h02208233; req_rs1 = 32'd3; req_rs2 = 32'd4;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if ({resp_valid, resp_wr, resp_rd_addr, resp_data, resp_trap} !==
          {1'b1, 1'b1, 5'd3, 32'd45, 1'b0} || req_ready !== 1'b0 || pcpi_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles required 0", bad); end
    handshake();
    n_checks++;
    if (req_ready !== 1'b1 || pcpi_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got rr=%b pv=%b required 1/0", req_ready, pcpi_valid);
    end
    @(negedge clk);
    req_valid = 1'b0; req_insn = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    n_checks++;
    if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h02208233) begin
      n_fail++; $display("FAIL bp_second_issue: got pv=%b insn=%h required 1/02208233", pcpi_valid, pcpi_insn);
    end
    respond(1, 0, 0, 1'b1, 32'd12, vcyc, stable);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rd_addr !== 5'd4 || resp_data !== 32'd12) begin
      n_fail++;
      $display("FAIL bp_second_resp: got v=%b rd=%0d data=%h required 1/4/0000000c",
               resp_valid, resp_rd_addr, resp_data);
    end
    handshake();
  endtask

  task automatic test_ready_at_timeout();
    int vcyc; bit stable;
    issue(32'h022081B3, 32'd2, 32'd3);
    respond(15, 0, 0, 1'b0, 32'hDEADBEEF, vcyc, stable);
    n_checks++;
    if (vcyc != 16) begin n_fail++; $display("FAIL rto_valid_cycles: got %0d required 16", vcyc); end
    n_checks++;
    if ({resp_valid, resp_trap, resp_wr, resp_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL rto_resp: got v=%b trap=%b wr=%b data=%h required 1/0/0/0",
               resp_valid, resp_trap, resp_wr, resp_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid_issue();
    int vcyc; bit stable;
    issue(32'h022081B3, 32'd7, 32'd6);
    pcpi_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (pcpi_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_async: got pv=%b rr=%b required 0/1", pcpi_valid, req_ready);
    end
    pcpi_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || pcpi_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got rv=%b rr=%b pv=%b required 0/1/0", resp_valid, req_ready, pcpi_valid);
    end
    issue(32'h02208233, 32'd10, 32'd10);
    respond(1, 2, 0, 1'b1, 32'd100, vcyc, stable);
    n_checks++;
    if ({vcyc == 4, resp_valid, resp_rd_addr, resp_data, resp_trap} !==
        {1'b1, 1'b1, 5'd4, 32'd100, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_new_txn: got cyc=%0d v=%b rd=%0d data=%h trap=%b required 4/1/4/00000064/0",
               vcyc, resp_valid, resp_rd_addr, resp_data, resp_trap);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_long_busy();
    test_busy_sticky();
    test_timeout();
    test_backpressure();
    test_ready_at_timeout();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
